// File: rtl/bp_update_scheduler_pkg.sv
// Shared encodings for the branch-predictor update scheduler.
// Update kinds, one-hot branch type positions, INIT type pattern.
package bp_pkg;

  typedef enum logic [1:0] {
    UPD_INIT    = 2'd0,
    UPD_CORRECT = 2'd1,
    UPD_RB_ID   = 2'd2,
    UPD_RB_EX   = 2'd3
  } upd_kind_e;

  localparam int T_BEQ  = 0;
  localparam int T_BNE  = 1;
  localparam int T_BLT  = 2;
  localparam int T_BGE  = 3;
  localparam int T_BLTU = 4;
  localparam int T_BGEU = 5;

  localparam logic [5:0] TYPE_INIT = 6'b111111;

endpackage

// File: rtl/bp_update_scheduler_if.sv
// Resolution input handshake and table update output handshake.
// master: scheduler side; slave: pipeline/table side.
interface bp_update_scheduler_if #(
  parameter int PC_W      = 32,
  parameter int TBL_IDX_W = 10
);
  logic                 res_valid;
  logic                 res_ready;
  logic [PC_W-1:0]      res_pc;
  logic                 res_taken;
  logic [5:0]           res_type;

  logic                 upd_valid;
  logic                 upd_ready;
  logic [1:0]           upd_kind;
  logic [PC_W-1:0]      upd_pc;
  logic                 upd_taken;
  logic [5:0]           upd_type;
  logic [TBL_IDX_W-1:0] upd_index;

  modport master (
    input  res_valid, res_pc, res_taken, res_type,
    output res_ready,
    output upd_valid, upd_kind, upd_pc,
    output upd_taken, upd_type, upd_index,
    input  upd_ready
  );

  modport slave (
    output res_valid, res_pc, res_taken, res_type,
    input  res_ready,
    input  upd_valid, upd_kind, upd_pc,
    input  upd_taken, upd_type, upd_index,
    output upd_ready
  );
endinterface

// File: rtl/bp_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers and combinational read data.
// Ports: push/din, pop/dout, full/empty flags.
module bp_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wp;
  logic [AW:0]      rp;
  logic [WIDTH-1:0] mem [DEPTH];

  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);
  assign empty = (wp == rp);
  assign dout  = mem[rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full)  wp <= wp + 1'b1;
      if (pop  && !empty) rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wp[AW-1:0]] <= din;
  end
endmodule

// File: rtl/bp_update_scheduler.sv
// Serialises table-clear sweep, resolutions and rollbacks onto one port.
// Ports: clk, rst_n, pl_stall, bus (res/upd), rb_id_*, rb_ex_*, flags.
module bp_update_scheduler
  import bp_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TBL_IDX_W  = 10,
  parameter int PC_W       = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pl_stall,
  bp_update_scheduler_if.master bus,
  input  logic            rb_id_valid,
  input  logic [PC_W-1:0] rb_id_pc,
  input  logic            rb_id_taken,
  input  logic [5:0]      rb_id_type,
  input  logic            rb_ex_valid,
  input  logic [PC_W-1:0] rb_ex_pc,
  input  logic            rb_ex_taken,
  input  logic [5:0]      rb_ex_type,
  output logic            init_done,
  output logic            rb_overrun
);
  localparam int EW = PC_W + 7;
  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
  localparam logic [TBL_IDX_W-1:0] IDX_LAST = '1;

  logic [0:0]           state;
  logic                 ex_v, id_v;
  logic [EW-1:0]        ex_d, id_d;
  logic                 o_v;
  logic [1:0]           o_kind;
  logic [PC_W-1:0]      o_pc;
  logic                 o_taken;
  logic [5:0]           o_type;
  logic [TBL_IDX_W-1:0] o_idx;

  logic          f_push, f_pop;
  logic          f_full, f_empty;
  logic [EW-1:0] f_dout;

  logic fire, load, init_last;
  logic run_load, init_beat;
  logic sel_ex, sel_id, sel_f;

  assign fire      = o_v & bus.upd_ready;
  assign load      = ~o_v | fire;
  // Last sweep beat accepted: pending work may follow at once.
  assign init_last = (state == S_INIT) & fire &
                     (o_idx == IDX_LAST);
  assign run_load  = load & ((state == S_RUN) | init_last);
  assign init_beat = load & (state == S_INIT) & ~init_last;
  assign sel_ex    = run_load & ex_v;
  assign sel_id    = run_load & ~ex_v & id_v;
  assign sel_f     = run_load & ~ex_v & ~id_v & ~f_empty;

  assign bus.res_ready = ~f_full & init_done;
  assign f_push = bus.res_valid & bus.res_ready & ~pl_stall;
  assign f_pop  = sel_f;

  assign bus.upd_valid = o_v;
  assign bus.upd_kind  = o_kind;
  assign bus.upd_pc    = o_pc;
  assign bus.upd_taken = o_taken;
  assign bus.upd_type  = o_type;
  assign bus.upd_index = o_idx;

  bp_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (f_push),
    .din   ({bus.res_pc, bus.res_taken, bus.res_type}),
    .pop   (f_pop),
    .dout  (f_dout),
    .full  (f_full),
    .empty (f_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_INIT;
      init_done  <= 1'b0;
      rb_overrun <= 1'b0;
      ex_v       <= 1'b0;
      id_v       <= 1'b0;
      ex_d       <= '0;
      id_d       <= '0;
      o_v        <= 1'b0;
      o_kind     <= 2'd0;
      o_pc       <= '0;
      o_taken    <= 1'b0;
      o_type     <= '0;
      o_idx      <= '0;
    end else begin
      if (init_last) begin
        state     <= S_RUN;
        init_done <= 1'b1;
      end

      if (sel_ex) begin
        ex_v <= 1'b0;
      end else if (rb_ex_valid && !ex_v) begin
        ex_v <= 1'b1;
        ex_d <= {rb_ex_pc, rb_ex_taken, rb_ex_type};
      end

      if (sel_id) begin
        id_v <= 1'b0;
      end else if (rb_id_valid && !id_v) begin
        id_v <= 1'b1;
        id_d <= {rb_id_pc, rb_id_taken, rb_id_type};
      end

      // An occupied slot keeps its older request.
      if ((rb_ex_valid && ex_v) || (rb_id_valid && id_v))
        rb_overrun <= 1'b1;

      if (load) begin
        unique case (1'b1)
          init_beat: begin
            o_v     <= 1'b1;
            o_kind  <= UPD_INIT;
            o_pc    <= '0;
            o_taken <= 1'b0;
            o_type  <= TYPE_INIT;
            o_idx   <= o_v ? o_idx + 1'b1 : '0;
          end
          sel_ex: begin
            o_v     <= 1'b1;
            o_kind  <= UPD_RB_EX;
            o_pc    <= ex_d[EW-1:7];
            o_taken <= ex_d[6];
            o_type  <= ex_d[5:0];
            o_idx   <= '0;
          end
          sel_id: begin
            o_v     <= 1'b1;
            o_kind  <= UPD_RB_ID;
            o_pc    <= id_d[EW-1:7];
            o_taken <= id_d[6];
            o_type  <= id_d[5:0];
            o_idx   <= '0;
          end
          sel_f: begin
            o_v     <= 1'b1;
            o_kind  <= UPD_CORRECT;
            o_pc    <= f_dout[EW-1:7];
            o_taken <= f_dout[6];
            o_type  <= f_dout[5:0];
            o_idx   <= '0;
          end
          default: begin
            o_v     <= 1'b0;
            o_kind  <= 2'd0;
            o_pc    <= '0;
            o_taken <= 1'b0;
            o_type  <= '0;
            o_idx   <= '0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_bp_update_scheduler.sv
// Testbench for bp_update_scheduler (TBL_IDX_W=3, FIFO_DEPTH=4).
// Directed scenarios plus randomized traffic against a queue model.
module tb_bp_update_scheduler;
  import bp_pkg::*;

  localparam int PC_W  = 32;
  localparam int IDX_W = 3;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] pc;
    logic        taken;
    logic [5:0]  typ;
    logic [2:0]  idx;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pl_stall = 1'b0;
  logic rb_id_valid = 1'b0;
  logic [31:0] rb_id_pc = '0;
  logic rb_id_taken = 1'b0;
  logic [5:0] rb_id_type = '0;
  logic rb_ex_valid = 1'b0;
  logic [31:0] rb_ex_pc = '0;
  logic rb_ex_taken = 1'b0;
  logic [5:0] rb_ex_type = '0;
  logic init_done;
  logic rb_overrun;

  int checks = 0;
  int errors = 0;
  beat_t got[$];

  always #5 clk = ~clk;

  bp_update_scheduler_if #(
    .PC_W(PC_W), .TBL_IDX_W(IDX_W)
  ) bus ();

  bp_update_scheduler #(
    .FIFO_DEPTH(DEPTH),
    .TBL_IDX_W(IDX_W),
    .PC_W(PC_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pl_stall(pl_stall),
    .bus(bus),
    .rb_id_valid(rb_id_valid),
    .rb_id_pc(rb_id_pc),
    .rb_id_taken(rb_id_taken),
    .rb_id_type(rb_id_type),
    .rb_ex_valid(rb_ex_valid),
    .rb_ex_pc(rb_ex_pc),
    .rb_ex_taken(rb_ex_taken),
    .rb_ex_type(rb_ex_type),
    .init_done(init_done),
    .rb_overrun(rb_overrun)
  );

  function automatic beat_t mk(logic [1:0] k,
    logic [31:0] pc, logic t, logic [5:0] ty,
    logic [2:0] ix);
    beat_t b;
    b.kind = k; b.pc = pc; b.taken = t;
    b.typ = ty; b.idx = ix;
    return b;
  endfunction

  function automatic beat_t cur();
    return mk(bus.upd_kind, bus.upd_pc,
      bus.upd_taken, bus.upd_type, bus.upd_index);
  endfunction

  // Sample at negedge (records accepted beats), then step.
  task automatic tick();
    @(negedge clk);
    if (bus.upd_valid === 1'b1 && bus.upd_ready === 1'b1)
      got.push_back(cur());
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    got.delete();
    rst_n = 1'b0;
    bus.upd_ready = 1'b1;
    repeat (2) tick();
    checks++;
    if ({bus.upd_valid, bus.upd_kind, bus.upd_pc,
         bus.upd_taken, bus.upd_type, bus.upd_index,
         init_done, rb_overrun, bus.res_ready} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b kind=%0d pc=%h type=%b init_done=%b ovr=%b rdy=%b, want all 0",
        bus.upd_valid, bus.upd_kind, bus.upd_pc,
        bus.upd_type, init_done, rb_overrun, bus.res_ready);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (bus.upd_valid !== 1'b1 || init_done !== 1'b0 ||
          cur() !== mk(UPD_INIT, 32'h0, 1'b0, 6'h3f, i[2:0])) begin
        errors++;
        $display("FAIL sweep_beat%0d: valid=%b kind=%0d idx=%0d type=%b done=%b, want INIT idx %0d",
          i, bus.upd_valid, bus.upd_kind, bus.upd_index,
          bus.upd_type, init_done, i);
      end
    end
    tick();
    checks++;
    if (init_done !== 1'b1 || bus.upd_valid !== 1'b0 ||
        bus.res_ready !== 1'b1) begin
      errors++;
      $display("FAIL sweep_end: done=%b valid=%b rdy=%b, want 1 0 1",
        init_done, bus.upd_valid, bus.res_ready);
    end
    checks++;
    if (got.size() != 8) begin
      errors++;
      $display("FAIL sweep_count: got %0d beats, want 8", got.size());
    end
  endtask

  task automatic test_single();
    beat_t e;
    got.delete();
    e = mk(UPD_CORRECT, 32'h100, 1'b1, 6'b000001, 3'd0);
    bus.res_valid = 1'b1;
    bus.res_pc = 32'h100;
    bus.res_taken = 1'b1;
    bus.res_type = 6'b000001;
    tick();
    bus.res_valid = 1'b0;
    checks++;
    if (bus.upd_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_latency: valid=%b at capture edge, want 0",
        bus.upd_valid);
    end
    tick();
    checks++;
    if (bus.upd_valid !== 1'b1 || cur() !== e) begin
      errors++;
      $display("FAIL single_beat: valid=%b beat=%h, want 1 %h",
        bus.upd_valid, cur(), e);
    end
    repeat (3) tick();
    checks++;
    if (got.size() != 1 || got[0] !== e ||
        bus.upd_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_once: beats=%0d valid=%b, want 1 beat then idle",
        got.size(), bus.upd_valid);
    end
  endtask

  task automatic test_fifo_full();
    beat_t exp[$];
    logic [5:0] ty;
    logic tk;
    got.delete();
    bus.upd_ready = 1'b0;
    rb_ex_valid = 1'b1;
    rb_ex_pc = 32'h300;
    rb_ex_taken = 1'b0;
    rb_ex_type = 6'b000010;
    exp.push_back(mk(UPD_RB_EX, 32'h300, 1'b0, 6'b000010, 3'd0));
    tick();
    rb_ex_valid = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      if (k == 2) begin
        pl_stall = 1'b1;
        bus.res_valid = 1'b1;
        bus.res_pc = 32'h4ee;
        tick();
        pl_stall = 1'b0;
      end
      tk = 1'($urandom_range(0, 1));
      ty = 6'b1 << $urandom_range(0, 5);
      bus.res_valid = 1'b1;
      bus.res_pc = 32'h400 + 32'(4 * k);
      bus.res_taken = tk;
      bus.res_type = ty;
      checks++;
      if (bus.res_ready !== 1'b1) begin
        errors++;
        $display("FAIL fill_ready%0d: res_ready=%b, want 1",
          k, bus.res_ready);
      end
      tick();
      exp.push_back(mk(UPD_CORRECT, 32'h400 + 32'(4 * k),
        tk, ty, 3'd0));
    end
    bus.res_pc = 32'h4ff;
    checks++;
    if (bus.res_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready: res_ready=%b after 4 entries, want 0",
        bus.res_ready);
    end
    repeat (2) tick();
    bus.res_valid = 1'b0;
    checks++;
    if (bus.res_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_hold: res_ready=%b, want 0", bus.res_ready);
    end
    bus.upd_ready = 1'b1;
    tick();
    checks++;
    if (bus.res_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_rise: res_ready=%b after first dequeue, want 1",
        bus.res_ready);
    end
    repeat (8) tick();
    checks++;
    if (got.size() != exp.size()) begin
      errors++;
      $display("FAIL fifo_count: got %0d beats, want %0d",
        got.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        errors++;
        $display("FAIL fifo_order%0d: got %h, want %h",
          i, (i < got.size()) ? got[i] : '0, exp[i]);
      end
    end
  endtask

  task automatic test_simultaneous();
    beat_t exp[3];
    got.delete();
    bus.upd_ready = 1'b1;
    exp[0] = mk(UPD_RB_EX, 32'h200, 1'b1, 6'b001000, 3'd0);
    exp[1] = mk(UPD_RB_ID, 32'h204, 1'b0, 6'b010000, 3'd0);
    exp[2] = mk(UPD_CORRECT, 32'h500, 1'b0, 6'b000100, 3'd0);
    bus.res_valid = 1'b1;
    bus.res_pc = 32'h500;
    bus.res_taken = 1'b0;
    bus.res_type = 6'b000100;
    rb_ex_valid = 1'b1;
    rb_ex_pc = 32'h200;
    rb_ex_taken = 1'b1;
    rb_ex_type = 6'b001000;
    rb_id_valid = 1'b1;
    rb_id_pc = 32'h204;
    rb_id_taken = 1'b0;
    rb_id_type = 6'b010000;
    tick();
    bus.res_valid = 1'b0;
    rb_ex_valid = 1'b0;
    rb_id_valid = 1'b0;
    repeat (6) tick();
    checks++;
    if (got.size() != 3) begin
      errors++;
      $display("FAIL simul_count: got %0d beats, want 3", got.size());
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        errors++;
        $display("FAIL simul_order%0d: got %h, want %h",
          i, (i < got.size()) ? got[i] : '0, exp[i]);
      end
    end
  endtask

  task automatic test_random();
    beat_t q_res[$];
    beat_t q_ex[$];
    beat_t q_id[$];
    beat_t prev;
    beat_t b;
    logic held;
    got.delete();
    for (int c = 0; c < 520; c++) begin
      if (c < 500) begin
        bus.upd_ready = ($urandom_range(0, 9) < 7);
        pl_stall = ($urandom_range(0, 9) < 2);
        bus.res_valid = ($urandom_range(0, 9) < 6);
        bus.res_pc = $urandom;
        bus.res_taken = 1'($urandom);
        bus.res_type = 6'($urandom);
        rb_ex_valid = (q_ex.size() == 0) &&
                      ($urandom_range(0, 9) == 0);
        rb_ex_pc = $urandom;
        rb_ex_taken = 1'($urandom);
        rb_ex_type = 6'($urandom);
        rb_id_valid = (q_id.size() == 0) &&
                      ($urandom_range(0, 9) == 0);
        rb_id_pc = $urandom;
        rb_id_taken = 1'($urandom);
        rb_id_type = 6'($urandom);
      end else begin
        bus.upd_ready = 1'b1;
        pl_stall = 1'b0;
        bus.res_valid = 1'b0;
        rb_ex_valid = 1'b0;
        rb_id_valid = 1'b0;
      end
      checks++;
      if ((bus.res_ready === 1'b0 && q_res.size() < DEPTH) ||
          (bus.res_ready === 1'b1 && q_res.size() > DEPTH)) begin
        errors++;
        $display("FAIL rand_ready c%0d: res_ready=%b with %0d outstanding",
          c, bus.res_ready, q_res.size());
      end
      if (bus.res_valid && bus.res_ready === 1'b1 && !pl_stall)
        q_res.push_back(mk(UPD_CORRECT, bus.res_pc,
          bus.res_taken, bus.res_type, 3'd0));
      if (rb_ex_valid)
        q_ex.push_back(mk(UPD_RB_EX, rb_ex_pc,
          rb_ex_taken, rb_ex_type, 3'd0));
      if (rb_id_valid)
        q_id.push_back(mk(UPD_RB_ID, rb_id_pc,
          rb_id_taken, rb_id_type, 3'd0));
      held = (bus.upd_valid === 1'b1) && !bus.upd_ready;
      prev = cur();
      tick();
      if (held) begin
        checks++;
        if (bus.upd_valid !== 1'b1 || cur() !== prev) begin
          errors++;
          $display("FAIL rand_hold c%0d: got %h valid=%b, want %h held",
            c, cur(), bus.upd_valid, prev);
        end
      end
      while (got.size() > 0) begin
        b = got.pop_front();
        checks++;
        if (b.kind == UPD_CORRECT && q_res.size() > 0 &&
            b === q_res[0])
          void'(q_res.pop_front());
        else if (b.kind == UPD_RB_EX && q_ex.size() > 0 &&
                 b === q_ex[0])
          void'(q_ex.pop_front());
        else if (b.kind == UPD_RB_ID && q_id.size() > 0 &&
                 b === q_id[0])
          void'(q_id.pop_front());
        else begin
          errors++;
          $display("FAIL rand_beat c%0d: unexpected beat %h", c, b);
        end
      end
    end
    checks++;
    if (q_res.size() + q_ex.size() + q_id.size() != 0 ||
        rb_overrun !== 1'b0) begin
      errors++;
      $display("FAIL rand_drain: res=%0d ex=%0d id=%0d left, ovr=%b, want 0",
        q_res.size(), q_ex.size(), q_id.size(), rb_overrun);
    end
  endtask

  task automatic test_overrun();
    beat_t e;
    got.delete();
    bus.upd_ready = 1'b0;
    e = mk(UPD_RB_ID, 32'h600, 1'b1, 6'b100000, 3'd0);
    checks++;
    if (rb_overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_pre: rb_overrun=%b, want 0", rb_overrun);
    end
    rb_id_valid = 1'b1;
    rb_id_pc = 32'h600;
    rb_id_taken = 1'b1;
    rb_id_type = 6'b100000;
    tick();
    rb_id_pc = 32'h604;
    rb_id_taken = 1'b0;
    tick();
    rb_id_valid = 1'b0;
    checks++;
    if (rb_overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_set: rb_overrun=%b, want 1", rb_overrun);
    end
    bus.upd_ready = 1'b1;
    repeat (4) tick();
    checks++;
    if (got.size() != 1 || got[0] !== e) begin
      errors++;
      $display("FAIL ovr_emit: %0d beats first=%h, want 1 beat %h",
        got.size(), (got.size() > 0) ? got[0] : '0, e);
    end
    checks++;
    if (rb_overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_sticky: rb_overrun=%b, want 1", rb_overrun);
    end
  endtask

  task automatic test_reset_mid();
    logic found;
    bus.upd_ready = 1'b0;
    bus.res_valid = 1'b1;
    bus.res_pc = 32'h700;
    tick();
    bus.res_pc = 32'h704;
    tick();
    bus.res_valid = 1'b0;
    rb_ex_valid = 1'b1;
    rb_ex_pc = 32'h708;
    tick();
    rb_ex_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    checks++;
    if ({bus.upd_valid, init_done, rb_overrun,
         bus.res_ready} !== 4'b0) begin
      errors++;
      $display("FAIL rst_run: valid=%b done=%b ovr=%b rdy=%b, want 0",
        bus.upd_valid, init_done, rb_overrun, bus.res_ready);
    end
    rst_n = 1'b1;
    bus.upd_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (bus.upd_valid === 1'b1 && bus.upd_index === 3'd5)
        found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reach_idx5: index 5 not seen in 20 cycles, want seen");
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (init_done !== 1'b0 || bus.upd_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: done=%b valid=%b, want 0 0",
        init_done, bus.upd_valid);
    end
    rst_n = 1'b1;
    got.delete();
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (bus.upd_valid !== 1'b1 ||
          cur() !== mk(UPD_INIT, 32'h0, 1'b0, 6'h3f, i[2:0])) begin
        errors++;
        $display("FAIL resweep%0d: valid=%b idx=%0d kind=%0d, want INIT idx %0d",
          i, bus.upd_valid, bus.upd_index, bus.upd_kind, i);
      end
    end
    repeat (4) tick();
    checks++;
    if (got.size() != 8 || init_done !== 1'b1 ||
        bus.upd_valid !== 1'b0) begin
      errors++;
      $display("FAIL resweep_end: beats=%0d done=%b valid=%b, want 8 1 0",
        got.size(), init_done, bus.upd_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.res_valid = 1'b0;
    bus.res_pc = '0;
    bus.res_taken = 1'b0;
    bus.res_type = '0;
    bus.upd_ready = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_fifo_full();
    test_simultaneous();
    test_random();
    test_overrun();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
      checks, errors);
    $finish;
  end
endmodule
